// File: rtl/xy_pkg.sv
// xy_pkg: shared widths, request field layout and FSM encoding for the XY segment scheduler
package xy_pkg;
  localparam int XY_XW = 8;
  localparam int XY_YW = 7;
  localparam int XY_SEG_W = 2 * XY_XW + 2 * XY_YW + 1;
  typedef enum logic [1:0] {IDLE, SETUP, STEP} state_t;
  typedef enum logic [2:0] {F_Y1, F_X1, F_Y0, F_X0, F_BEAM} field_t;
  function automatic int seg_off(field_t f, int xw, int yw);
    return f == F_Y1 ? 0 : f == F_X1 ? yw : f == F_Y0 ? xw + yw : f == F_X0 ? xw + 2 * yw : 2 * xw + 2 * yw;
  endfunction
endpackage

// File: rtl/xy_line_stepper.sv
// xy_line_stepper: Bresenham point walker; load latches a segment, step advances one point
module xy_line_stepper #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          at_end
);
  localparam int EW = XW + 2;
  logic [XW-1:0] x_q, x_d, xe_q, xe_d, adx;
  logic [YW-1:0] y_q, y_d, ye_q, ye_d, ady;
  logic signed [EW-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d;
  logic signed [EW:0] e2, ndy, pdx;
  logic sx_q, sx_d, sy_q, sy_d, mx, my;
  always_comb begin
    adx = x1 >= x0 ? x1 - x0 : x0 - x1;
    ady = y1 >= y0 ? y1 - y0 : y0 - y1;
    e2 = {err_q, 1'b0};
    ndy = -{1'b0, dy_q};
    pdx = {1'b0, dx_q};
    mx = e2 > ndy;
    my = e2 < pdx;
    at_end = x_q == xe_q && y_q == ye_q;
    x_d = x_q;
    y_d = y_q;
    xe_d = xe_q;
    ye_d = ye_q;
    sx_d = sx_q;
    sy_d = sy_q;
    dx_d = dx_q;
    dy_d = dy_q;
    err_d = err_q;
    if (load) begin
      x_d = x0;
      y_d = y0;
      xe_d = x1;
      ye_d = y1;
      sx_d = x1 < x0;
      sy_d = y1 < y0;
      dx_d = {2'b0, adx};
      dy_d = {{(EW - YW){1'b0}}, ady};
      err_d = dx_d - dy_d;
    end else if (step) begin
      // both axis decisions use the pre-step error term
      x_d = mx ? (sx_q ? x_q - 1'b1 : x_q + 1'b1) : x_q;
      y_d = my ? (sy_q ? y_q - 1'b1 : y_q + 1'b1) : y_q;
      err_d = err_q - (mx ? dy_q : '0) + (my ? dx_q : '0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      xe_q <= '0;
      ye_q <= '0;
      sx_q <= 1'b0;
      sy_q <= 1'b0;
      dx_q <= '0;
      dy_q <= '0;
      err_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      xe_q <= xe_d;
      ye_q <= ye_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      err_q <= err_d;
    end
  end
  assign x = x_q;
  assign y = y_q;
endmodule

// File: rtl/xy_segment_scheduler.sv
// xy_segment_scheduler: round-robin segment arbiter, dwell timer and blanking for BNC X/Y outputs
module xy_segment_scheduler
  import xy_pkg::*;
#(
  parameter int XW = XY_XW,
  parameter int YW = XY_YW,
  parameter int DWELL_W = 4,
  localparam int SEG_W = 2 * XW + 2 * YW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         req_valid,
  input  logic [2*SEG_W-1:0] req_seg,
  output logic [1:0]         req_ready,
  output logic [XW-1:0]      BNC_x,
  output logic [YW-1:0]      BNC_y,
  output logic               BNC_blank,
  output logic               busy,
  output logic               seg_done,
  output logic               grant_id
);
  localparam int OB = seg_off(F_BEAM, XW, YW);
  localparam int OX0 = seg_off(F_X0, XW, YW);
  localparam int OY0 = seg_off(F_Y0, XW, YW);
  localparam int OX1 = seg_off(F_X1, XW, YW);
  localparam int OY1 = seg_off(F_Y1, XW, YW);
  state_t state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic grant_q, grant_d, blank_q, blank_d;
  logic g, accept, load, step, at_end;
  always_comb begin
    g = &req_valid ? ~grant_q : req_valid[1];
    accept = state_q == IDLE && enable && |req_valid && !reset;
    req_ready = accept ? (g ? 2'b10 : 2'b01) : 2'b00;
    load = state_q == SETUP;
    seg_done = state_q == STEP && cnt_q == '0 && at_end;
    step = state_q == STEP && cnt_q == '0 && !at_end;
    busy = state_q != IDLE;
    state_d = state_q;
    seg_d = seg_q;
    dwell_d = dwell_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    blank_d = blank_q;
    if (accept) begin
      seg_d = g ? req_seg[2*SEG_W-1:SEG_W] : req_seg[SEG_W-1:0];
      dwell_d = dwell;
      grant_d = g;
      state_d = SETUP;
    end else if (state_q == SETUP) begin
      cnt_d = dwell_q;
      blank_d = ~seg_q[OB];
      state_d = STEP;
    end else if (state_q == STEP) begin
      cnt_d = cnt_q == '0 ? dwell_q : cnt_q - 1'b1;
      blank_d = seg_done ? 1'b1 : blank_q;
      state_d = seg_done ? IDLE : STEP;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      seg_q <= '0;
      dwell_q <= '0;
      cnt_q <= '0;
      grant_q <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      seg_q <= seg_d;
      dwell_q <= dwell_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      blank_q <= blank_d;
    end
  end
  xy_line_stepper #(.XW(XW), .YW(YW)) u_stepper (
    .clk(clk),
    .reset(reset),
    .load(load),
    .step(step),
    .x0(seg_q[OX0 +: XW]),
    .y0(seg_q[OY0 +: YW]),
    .x1(seg_q[OX1 +: XW]),
    .y1(seg_q[OY1 +: YW]),
    .x(BNC_x),
    .y(BNC_y),
    .at_end(at_end)
  );
  assign BNC_blank = blank_q;
  assign grant_id = grant_q;
endmodule
